// File: rtl/vga_frame_fetch.sv
// Fetches one video frame from DDR into the pixel FIFO as fixed-length read bursts.
// Requests are issued only when the FIFO has room for all data already in flight.
module vga_frame_fetch #(
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned FRAME_WORDS = 76800,
  parameter int unsigned FIFO_DEPTH  = 512
) (
  input  logic        vga_clk,
  input  logic        vga_reset_n,
  input  logic        enable,
  input  logic [31:0] frame_base,
  input  logic        vsync_start,
  input  logic [9:0]  fifo_level,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  output logic [7:0]  rd_burst,
  input  logic        rd_ack,
  input  logic        rd_data_valid,
  output logic        fifo_flush,
  output logic        busy,
  output logic        frame_err
);

  localparam logic [10:0] BURST_W     = 11'(BURST_LEN);
  localparam logic [10:0] DEPTH_W     = 11'(FIFO_DEPTH);
  localparam logic [31:0] ADDR_STEP   = 32'(BURST_LEN * 16);
  localparam logic [31:0] WORDS_INIT  = 32'(FRAME_WORDS);
  localparam logic [31:0] BURST_WORDS = 32'(BURST_LEN);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    REQ   = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] words_left_q, words_left_d;
  logic [10:0] outstanding_q, outstanding_d;
  logic        restart_pend_q, restart_pend_d;
  logic        frame_err_q, frame_err_d;
  logic        rd_req_q, rd_req_d;
  logic        fifo_flush_q, fifo_flush_d;
  logic        busy_q, busy_d;

  logic accept;
  logic beat_dec;
  logic start_frame;
  logic room_ok;

  // A burst may go out only if FIFO contents, in-flight beats and the new burst all fit.
  function automatic logic credit_ok_f(input logic [9:0] level, input logic [10:0] outst);
    logic [10:0] sum;
    sum = {1'b0, level} + outst + BURST_W;
    return (sum <= DEPTH_W);
  endfunction

  // Handshake, beat-return and frame-start qualifiers.
  always_comb begin
    accept      = rd_req_q & rd_ack;
    beat_dec    = rd_data_valid & (outstanding_q != 11'd0);
    start_frame = vsync_start & enable;
    room_ok     = credit_ok_f(fifo_level, outstanding_q);
  end

  // In-flight beat counter; stray beats at zero are ignored.
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && beat_dec) begin
      outstanding_d = outstanding_q + BURST_W - 11'd1;
    end else if (accept) begin
      outstanding_d = outstanding_q + BURST_W;
    end else if (beat_dec) begin
      outstanding_d = outstanding_q - 11'd1;
    end else begin
      outstanding_d = outstanding_q;
    end
  end

  // Next-state logic for the fetch sequencer and its frame bookkeeping.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    words_left_d   = words_left_q;
    restart_pend_d = restart_pend_q;
    frame_err_d    = frame_err_q;
    fifo_flush_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_frame) begin
          state_d        = CHECK;
          addr_d         = frame_base;
          words_left_d   = WORDS_INIT;
          restart_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (vsync_start) begin
          frame_err_d    = 1'b1;
          restart_pend_d = 1'b1;
          state_d        = DRAIN;
        end else if (restart_pend_q) begin
          state_d = DRAIN;
        end else if (room_ok) begin
          state_d = REQ;
        end else begin
          state_d = CHECK;
        end
      end
      REQ: begin
        if (vsync_start) begin
          frame_err_d    = 1'b1;
          restart_pend_d = 1'b1;
        end else begin
          restart_pend_d = restart_pend_q;
        end
        // The request is never withdrawn; a restart waits for the accept.
        if (accept) begin
          addr_d       = addr_q + ADDR_STEP;
          words_left_d = words_left_q - BURST_WORDS;
          if (vsync_start || restart_pend_q) begin
            state_d = DRAIN;
          end else if (words_left_q == BURST_WORDS) begin
            state_d = DONE;
          end else begin
            state_d = CHECK;
          end
        end else begin
          state_d = REQ;
        end
      end
      DONE: begin
        if (start_frame) begin
          state_d        = CHECK;
          addr_d         = frame_base;
          words_left_d   = WORDS_INIT;
          restart_pend_d = 1'b0;
        end else if (!enable) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      DRAIN: begin
        // Stale beats must land before the FIFO is cleared for the new frame.
        if (outstanding_q == 11'd0) begin
          state_d        = CHECK;
          fifo_flush_d   = 1'b1;
          addr_d         = frame_base;
          words_left_d   = WORDS_INIT;
          restart_pend_d = 1'b0;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rd_req_d = (state_d == REQ);
    busy_d   = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge vga_clk or negedge vga_reset_n) begin
    if (!vga_reset_n) begin
      state_q        <= IDLE;
      addr_q         <= 32'd0;
      words_left_q   <= 32'd0;
      outstanding_q  <= 11'd0;
      restart_pend_q <= 1'b0;
      frame_err_q    <= 1'b0;
      rd_req_q       <= 1'b0;
      fifo_flush_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      words_left_q   <= words_left_d;
      outstanding_q  <= outstanding_d;
      restart_pend_q <= restart_pend_d;
      frame_err_q    <= frame_err_d;
      rd_req_q       <= rd_req_d;
      fifo_flush_q   <= fifo_flush_d;
      busy_q         <= busy_d;
    end
  end

  assign rd_req     = rd_req_q;
  assign rd_addr    = addr_q;
  assign rd_burst   = 8'(BURST_LEN);
  assign fifo_flush = fifo_flush_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;

endmodule

// File: doc/vga_frame_fetch.md
VGA_FRAME_FETCH -- requirements
Module: vga_frame_fetch

Interface
Parameters:
REQ-001 SHALL have parameter BURST_LEN, default 16, meaning 128-bit beats per DDR read burst.
REQ-002 SHALL have parameter FRAME_WORDS, default 76800, meaning 128-bit words per frame (640x480, 4 px/word); SHALL be a multiple of BURST_LEN.
REQ-003 SHALL have parameter FIFO_DEPTH, default 512, meaning pixel FIFO capacity in 128-bit words.
Ports:
REQ-004 SHALL have port vga_clk, input, 1, meaning clock; all logic is on its rising edge.
REQ-005 SHALL have port vga_reset_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1, meaning level; allows frame fetching to start.
REQ-007 SHALL have port frame_base, input, 32, meaning byte address of the frame, 16-byte aligned, sampled at frame start.
REQ-008 SHALL have port vsync_start, input, 1, meaning one-cycle pulse at start of a new frame.
REQ-009 SHALL have port fifo_level, input, 10, meaning words currently held in the pixel FIFO.
REQ-010 SHALL have port rd_req, output, 1, meaning DDR read burst request.
REQ-011 SHALL have port rd_addr, output, 32, meaning burst byte address.
REQ-012 SHALL have port rd_burst, output, 8, meaning burst length in beats; constant BURST_LEN.
REQ-013 SHALL have port rd_ack, input, 1, meaning DDR has accepted the request.
REQ-014 SHALL have port rd_data_valid, input, 1, meaning one returned beat is being written into the FIFO this cycle.
REQ-015 SHALL have port fifo_flush, output, 1, meaning one-cycle pulse that clears the pixel FIFO.
REQ-016 SHALL have port busy, output, 1, meaning high in any state except IDLE.
REQ-017 SHALL have port frame_err, output, 1, meaning sticky; a frame restarted before its fetch completed.

Function
REQ-018 SHALL implement states IDLE, CHECK, REQ, DONE and DRAIN.
REQ-019 IDLE -> CHECK on vsync_start & enable; this transition SHALL latch frame_base into addr, load words_left=FRAME_WORDS and clear restart_pend.
REQ-020 CHECK -> REQ when fifo_level + outstanding + BURST_LEN <= FIFO_DEPTH; the sum SHALL be computed at 11 bits with no overflow; otherwise the block stays in CHECK.
REQ-021 rd_req SHALL be high throughout REQ with rd_addr and rd_burst stable; a request SHALL never be withdrawn before rd_ack.
REQ-022 On rd_req & rd_ack: outstanding += BURST_LEN, addr += BURST_LEN*16 (mod 2^32), words_left -= BURST_LEN.
REQ-023 After rd_ack the next state SHALL be DONE if words_left becomes 0, else CHECK; back-to-back requests SHALL therefore be at least 2 cycles apart.
REQ-024 outstanding SHALL be 11 bits and decrement by 1 per rd_data_valid.
REQ-025 An accept and a returned beat in the same cycle SHALL net to +BURST_LEN-1.
REQ-026 rd_data_valid while outstanding==0 SHALL be ignored; the counter SHALL saturate at 0.
REQ-027 DONE: vsync_start & enable SHALL re-enter CHECK with a new latch (as REQ-019).
REQ-028 DONE: !enable SHALL go to IDLE.
REQ-029 vsync_start in CHECK or REQ SHALL set frame_err and restart_pend.
REQ-030 With restart_pend set, CHECK SHALL go to DRAIN; REQ SHALL complete its handshake and then go to DRAIN.
REQ-031 DRAIN SHALL wait for outstanding==0, then pulse fifo_flush for one cycle, then go to CHECK with a new latch.
REQ-032 Deasserting enable SHALL not abort a frame in progress; IDLE is re-entered only from DONE.
REQ-033 vsync_start in IDLE with enable low SHALL be ignored.
REQ-034 vsync_start coincident with the final rd_ack SHALL be treated as a restart (frame_err set).

Reset
REQ-035 vga_reset_n low SHALL asynchronously force state=IDLE, rd_req=0, rd_addr=0, rd_burst=BURST_LEN, fifo_flush=0, busy=0, frame_err=0, outstanding=0, words_left=0, restart_pend=0.
REQ-036 Reset mid-burst SHALL drop rd_req immediately; DDR side recovery is outside this block.
REQ-037 frame_err SHALL be cleared only by reset.

Verification
REQ-038 SHALL cover: enable=1, frame_base=0x1000_0000, vsync pulse, fifo_level=0, rd_ack same cycle as rd_req, data returned 8 cycles after ack -> 4800 bursts at 0x1000_0000 + n*0x100, DONE, frame_err=0.
REQ-039 SHALL cover: fifo_level=496, outstanding=0 -> exactly one request issued; fifo_level=497 -> no request until the level falls.
REQ-040 SHALL cover: rd_ack delayed 20 cycles -> rd_req and rd_addr held constant for 20 cycles, a single accept counted.
REQ-041 SHALL cover: vsync_start during burst 100 with 16 beats outstanding -> frame_err=1, handshake finishes, fifo_flush pulses once after the last beat, next request at the new frame_base.
REQ-042 SHALL cover: accept and rd_data_valid in the same cycle with outstanding=5 -> outstanding=20.
REQ-043 SHALL cover: reset asserted while rd_req=1 -> rd_req=0 immediately, all outputs at reset values, next vsync starts cleanly.
